tpu_ctrl_word_decoder: RTL and testbench

//  Consumes the 32-bit control word driven by the HPS-writable control PIO (FPGA side).

---
 rtl/tpu_ctrl_pkg.sv | 50 +++++
 rtl/tpu_ctrl_status_reg.sv | 45 ++++
 rtl/tpu_ctrl_word_decoder.sv | 138 +++++++++++++
 tb/tb_tpu_ctrl_word_decoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared opcodes, FSM encoding and control/status bit-field positions for the TPU control-word decoder.
package tpu_ctrl_pkg;

  localparam int unsigned OP_W       = 3;
  localparam int unsigned ARG_W      = 12;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned STAT_CNT_W = 16;

  localparam logic [OP_W-1:0] OP_NOP      = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD_W   = 3'd1;
  localparam logic [OP_W-1:0] OP_LOAD_A   = 3'd2;
  localparam logic [OP_W-1:0] OP_RUN      = 3'd3;
  localparam logic [OP_W-1:0] OP_READ_OUT = 3'd4;
  localparam logic [OP_W-1:0] OP_CLEAR    = 3'd5;

  // Control word layout
  localparam int unsigned CTRL_TOG      = 31;
  localparam int unsigned CTRL_OP_MSB   = 30;
  localparam int unsigned CTRL_OP_LSB   = 28;
  localparam int unsigned CTRL_ARG_MSB  = 27;
  localparam int unsigned CTRL_ARG_LSB  = 16;
  localparam int unsigned CTRL_ADDR_MSB = 15;
  localparam int unsigned CTRL_ADDR_LSB = 0;

  // Status word layout
  localparam int unsigned ST_ACK     = 31;
  localparam int unsigned ST_BUSY    = 30;
  localparam int unsigned ST_ERR     = 29;
  localparam int unsigned ST_OP_MSB  = 28;
  localparam int unsigned ST_OP_LSB  = 26;
  localparam int unsigned ST_CNT_MSB = 15;
  localparam int unsigned ST_CNT_LSB = 0;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // Opcodes that are handed to the TPU core; NOP and 6/7 complete locally.
  function automatic logic op_needs_core(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD_W, OP_LOAD_A, OP_RUN, OP_READ_OUT, OP_CLEAR: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tpu_ctrl_status_reg.sv
// Registered FPGA-to-HPS status word and completion interrupt pulse.
module tpu_ctrl_status_reg
  import tpu_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_en,
  input  logic                  init_tog,
  input  logic                  accept_en,
  input  logic                  done_en,
  input  logic                  done_tog,
  input  logic                  done_err,
  input  logic [OP_W-1:0]       done_op,
  input  logic [STAT_CNT_W-1:0] done_cnt,
  output logic [31:0]           status_word,
  output logic                  busy,
  output logic                  irq_pulse
);

  // Fields are written in place so the word never has a combinational path from the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_word <= '0;
      irq_pulse   <= 1'b0;
    end else begin
      irq_pulse <= done_en;
      if (init_en) begin
        status_word[ST_ACK] <= init_tog;
      end
      if (accept_en) begin
        status_word[ST_BUSY] <= 1'b1;
      end
      if (done_en) begin
        status_word[ST_ACK]                  <= done_tog;
        status_word[ST_BUSY]                 <= 1'b0;
        status_word[ST_ERR]                  <= done_err;
        status_word[ST_OP_MSB:ST_OP_LSB]     <= done_op;
        status_word[ST_CNT_MSB:ST_CNT_LSB]   <= done_cnt;
      end
    end
  end

  assign busy = status_word[ST_BUSY];

endmodule

// File: rtl/tpu_ctrl_word_decoder.sv
// Decodes toggle-triggered commands from the control PIO into a valid/ready TPU command and tracks completion.
// Optional busy-cycle counter in the status word: define TPU_CTRL_CYCLE_COUNT_EN.
module tpu_ctrl_word_decoder
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ctrl_word,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [OP_W-1:0]   cmd_op,
  output logic [ARG_W-1:0]  cmd_arg,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              core_done,
  output logic              busy,
  output logic              irq_pulse,
  output logic [31:0]       status_word
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  state_t             state;
  logic [31:0]        ctrl_q;
  logic               accepted_tog;
  logic               err_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [CNT_W-1:0]   busy_cnt;
  logic               pending_c;
  logic               accept_c;
  logic               init_c;
  logic               done_c;
  logic [OP_W-1:0]    req_op_c;

  assign pending_c = ctrl_q[CTRL_TOG] != accepted_tog;
  assign accept_c  = (state == S_IDLE) && pending_c;
  assign init_c    = (state == S_INIT);
  assign done_c    = (state == S_DONE);
  assign req_op_c  = ctrl_q[CTRL_OP_MSB:CTRL_OP_LSB];

  // Command FSM and latch. INIT takes the toggle arriving in ctrl_q on the same edge,
  // so a toggle already set across reset is treated as acknowledged, not as a new request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_INIT;
      ctrl_q       <= '0;
      accepted_tog <= 1'b0;
      err_q        <= 1'b0;
      tmo_cnt      <= '0;
      cmd_valid    <= 1'b0;
      cmd_op       <= '0;
      cmd_arg      <= '0;
      cmd_addr     <= '0;
    end else begin
      ctrl_q <= ctrl_word;
      case (state)
        S_INIT: begin
          accepted_tog <= ctrl_word[CTRL_TOG];
          state        <= S_IDLE;
        end
        S_IDLE: begin
          if (pending_c) begin
            cmd_op       <= req_op_c;
            cmd_arg      <= ctrl_q[CTRL_ARG_MSB:CTRL_ARG_LSB];
            cmd_addr     <= ctrl_q[CTRL_ADDR_MSB:CTRL_ADDR_LSB];
            accepted_tog <= ctrl_q[CTRL_TOG];
            err_q        <= 1'b0;
            tmo_cnt      <= '0;
            if (op_needs_core(req_op_c)) begin
              cmd_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              err_q <= (req_op_c != OP_NOP);
              state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            state <= S_DONE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= S_INIT;
        end
      endcase
    end
  end

`ifdef TPU_CTRL_CYCLE_COUNT_EN
  // Saturating count of ISSUE+WAIT cycles for the current command.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt <= '0;
    end else if (accept_c) begin
      busy_cnt <= '0;
    end else if ((state == S_ISSUE || state == S_WAIT) && !(&busy_cnt)) begin
      busy_cnt <= busy_cnt + CNT_W'(1);
    end
  end
`else
  assign busy_cnt = '0;
`endif

  tpu_ctrl_status_reg u_status (
    .clk         (clk),
    .reset       (reset),
    .init_en     (init_c),
    .init_tog    (ctrl_word[CTRL_TOG]),
    .accept_en   (accept_c),
    .done_en     (done_c),
    .done_tog    (accepted_tog),
    .done_err    (err_q),
    .done_op     (cmd_op),
    .done_cnt    (STAT_CNT_W'(busy_cnt)),
    .status_word (status_word),
    .busy        (busy),
    .irq_pulse   (irq_pulse)
  );

endmodule

// File: tb/tb_tpu_ctrl_word_decoder.sv
// Self-checking bench for tpu_ctrl_word_decoder: vector table, corner-case sequences and randomized commands.
module tb_tpu_ctrl_word_decoder;

  localparam int TMO     = 20;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ctrl_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [11:0] cmd_arg;
  logic [15:0] cmd_addr;
  logic        core_done;
  logic        busy;
  logic        irq_pulse;
  logic [31:0] status_word;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic host_tog = 1'b0;

  tpu_ctrl_word_decoder #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl_word   (ctrl_word),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .cmd_addr    (cmd_addr),
    .core_done   (core_done),
    .busy        (busy),
    .irq_pulse   (irq_pulse),
    .status_word (status_word)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [11:0] arg;
    logic [15:0] addr;
    int          r;      // cycles cmd_ready held low
    int          d;      // WAIT cycles before core_done
    bit          issue;
    bit          err;
    int          cnt;    // expected busy-cycle count (already saturated)
  } vec_t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level expectation: how a command completes, from its opcode and the core's response timing.
  function automatic void model(input logic [2:0] op, input int r, input int d,
                                output bit issue, output bit err, output int cnt);
    int wait_cycles;
    issue = (op >= 3'd1) && (op <= 3'd5);
    if (!issue) begin
      err = (op >= 3'd6);
      cnt = 0;
    end else begin
      wait_cycles = (d + 1 < TMO) ? d + 1 : TMO;
      err = (d >= TMO);
      cnt = r + 1 + wait_cycles;
      if (cnt > CNT_MAX) cnt = CNT_MAX;
    end
  endfunction

  function automatic logic [15:0] cnt_field(input int cnt);
`ifdef TPU_CTRL_CYCLE_COUNT_EN
    return 16'(cnt);
`else
    return (cnt < 0) ? 16'hFFFF : 16'h0;
`endif
  endfunction

  task automatic do_reset(input logic [31:0] cw);
    reset     = 1'b1;
    ctrl_word = cw;
    host_tog  = cw[31];
    cmd_ready = 1'b0;
    core_done = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {cmd_valid, busy, irq_pulse, cmd_op, 1'b0, cmd_arg, cmd_addr}, 32'h0);
    chk("reset_status", status_word, 32'h0);
    reset = 1'b0;
    tick();
    tick();
    chk("init_status", status_word, {cw[31], 31'h0});
    repeat (3) tick();
    chk("init_no_spurious", {29'h0, cmd_valid, busy, irq_pulse}, 32'h0);
  endtask

  // One complete command: toggle, accept, optional handshake/completion, then status check.
  task automatic exec(input string tag, input logic [2:0] op, input logic [11:0] arg, input logic [15:0] addr,
                      input int r, input int d, input bit exp_issue, input bit exp_err, input int exp_cnt);
    int lat;
    bit seen;
    host_tog  = ~host_tog;
    ctrl_word = {host_tog, op, arg, addr};
    tick();
    chk({tag, ".pre_accept"}, {30'h0, busy, cmd_valid}, 32'h0);
    tick();
    chk({tag, ".accept"}, {29'h0, busy, cmd_valid, irq_pulse}, {29'h0, 1'b1, exp_issue, 1'b0});
    if (exp_issue) begin
      chk({tag, ".fields"}, {1'b0, cmd_op, cmd_arg, cmd_addr}, {1'b0, op, arg, addr});
      for (int i = 0; i < r; i++) begin
        cmd_ready = 1'b0;
        tick();
        chk({tag, ".held"}, {cmd_valid, cmd_op, cmd_arg, cmd_addr}, {1'b1, op, arg, addr});
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk({tag, ".valid_drop"}, 32'(cmd_valid), 32'h0);
      seen = 1'b0;
      lat  = 0;
      for (int k = 0; k < d + TMO + 4 && !seen; k++) begin
        core_done = (k == d);
        ctrl_word = {host_tog, 31'($urandom)};
        tick();
        core_done = 1'b0;
        lat++;
        if (irq_pulse) seen = 1'b1;
      end
      chk({tag, ".irq_latency"}, 32'(lat), 32'(((d < TMO) ? d : TMO - 1) + 2));
    end else begin
      tick();
      chk({tag, ".irq_latency"}, 32'(irq_pulse), 32'h1);
    end
    chk({tag, ".status"}, status_word,
        {host_tog, 1'b0, exp_err, op, 10'h0, cnt_field(exp_cnt)});
    chk({tag, ".latched"}, {busy, cmd_valid, cmd_op, 1'b0, cmd_arg, cmd_addr}, {2'b00, op, 1'b0, arg, addr});
    tick();
    chk({tag, ".irq_single"}, 32'(irq_pulse), 32'h0);
  endtask

  vec_t tbl[11];

  initial begin
    logic       t1;
    logic [2:0] rop;
    bit         m_issue;
    bit         m_err;
    int         m_cnt;
    int         rr;
    int         dd;

    tbl[0]  = '{3'd3, 12'd5,     16'h1234, 0, 10, 1'b1, 1'b0, 12};
    tbl[1]  = '{3'd0, 12'hABC,   16'h5555, 0, 0,  1'b0, 1'b0, 0};
    tbl[2]  = '{3'd7, 12'h001,   16'h0002, 0, 0,  1'b0, 1'b1, 0};
    tbl[3]  = '{3'd1, 12'h010,   16'h8000, 5, 3,  1'b1, 1'b0, 10};
    tbl[4]  = '{3'd2, 12'hFFF,   16'hFFFF, 1, 0,  1'b1, 1'b0, 3};
    tbl[5]  = '{3'd4, 12'h123,   16'h0040, 2, 19, 1'b1, 1'b0, 15};
    tbl[6]  = '{3'd5, 12'h000,   16'h0000, 0, 25, 1'b1, 1'b1, 15};
    tbl[7]  = '{3'd0, 12'h000,   16'h0001, 0, 0,  1'b0, 1'b0, 0};
    tbl[8]  = '{3'd6, 12'h777,   16'h7777, 0, 0,  1'b0, 1'b1, 0};
    tbl[9]  = '{3'd3, 12'h002,   16'h0100, 0, 12, 1'b1, 1'b0, 14};
    tbl[10] = '{3'd3, 12'h003,   16'h0200, 1, 13, 1'b1, 1'b0, 15};

    reset = 1'b1; ctrl_word = '0; cmd_ready = 1'b0; core_done = 1'b0;

    // Toggle already set across reset must not fire; then restart from toggle 0.
    do_reset(32'h8000_0000);
    do_reset(32'h0000_0000);

    for (int i = 0; i < 11; i++) begin
      exec($sformatf("vec%0d", i), tbl[i].op, tbl[i].arg, tbl[i].addr, tbl[i].r, tbl[i].d,
           tbl[i].issue, tbl[i].err, tbl[i].cnt);
    end

    // Back-pressure, then a re-toggle during WAIT that must issue right after DONE.
    host_tog  = ~host_tog;
    t1        = host_tog;
    ctrl_word = {t1, 3'd3, 12'd7, 16'hBEEF};
    tick(); tick();
    chk("bp.valid", 32'(cmd_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cmd_ready = 1'b0;
      tick();
      chk("bp.held", {cmd_valid, cmd_op, cmd_arg, cmd_addr}, {1'b1, 3'd3, 12'd7, 16'hBEEF});
    end
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    host_tog  = ~host_tog;
    ctrl_word = {host_tog, 3'd1, 12'd9, 16'h00A0};
    repeat (3) tick();
    core_done = 1'b1; tick(); core_done = 1'b0;
    chk("bp.no_early_irq", 32'(irq_pulse), 32'h0);
    tick();
    chk("bp.first_irq", 32'(irq_pulse), 32'h1);
    chk("bp.first_status", status_word, {t1, 1'b0, 1'b0, 3'd3, 10'h0, cnt_field(10)});
    tick();
    chk("bp.second_accept", {cmd_valid, busy, irq_pulse, cmd_op, cmd_arg, cmd_addr},
        {1'b1, 1'b1, 1'b0, 3'd1, 12'd9, 16'h00A0});
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    core_done = 1'b1; tick(); core_done = 1'b0;
    tick();
    chk("bp.second_irq", 32'(irq_pulse), 32'h1);
    chk("bp.second_status", status_word, {host_tog, 1'b0, 1'b0, 3'd1, 10'h0, cnt_field(2)});
    tick();

    // Double toggle while busy leaves nothing pending.
    host_tog  = ~host_tog;
    ctrl_word = {host_tog, 3'd2, 12'd1, 16'h0001};
    tick(); tick();
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    ctrl_word = {~host_tog, 3'd4, 12'd2, 16'h0002};
    tick();
    ctrl_word = {host_tog, 3'd4, 12'd2, 16'h0002};
    tick();
    core_done = 1'b1; tick(); core_done = 1'b0;
    tick();
    chk("dbl.irq", 32'(irq_pulse), 32'h1);
    repeat (3) tick();
    chk("dbl.no_cmd", {30'h0, cmd_valid, busy}, 32'h0);
    chk("dbl.status_ack", 32'(status_word[31]), 32'(host_tog));

    // Reset in ISSUE (ph 0) and in WAIT (ph 1): command discarded, no irq, no re-issue after INIT.
    for (int ph = 0; ph < 2; ph++) begin
      host_tog  = ~host_tog;
      ctrl_word = {host_tog, 3'd3, 12'd1, 16'h0F0F};
      cmd_ready = 1'b0;
      tick(); tick();
      chk($sformatf("rst%0d.valid", ph), 32'(cmd_valid), 32'h1);
      if (ph == 1) begin
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0; tick();
      end
      reset = 1'b1;
      tick();
      chk($sformatf("rst%0d.outputs", ph), {29'h0, cmd_valid, busy, irq_pulse}, 32'h0);
      chk($sformatf("rst%0d.status", ph), status_word, 32'h0);
      reset     = 1'b0;
      core_done = 1'b1; tick(); core_done = 1'b0;
      tick(); tick();
      chk($sformatf("rst%0d.after", ph), {29'h0, cmd_valid, busy, irq_pulse}, 32'h0);
      chk($sformatf("rst%0d.ack", ph), status_word, {host_tog, 31'h0});
    end

    // Randomized commands against the spec-level model.
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      rr  = int'($urandom_range(0, 3));
      dd  = int'($urandom_range(0, 24));
      model(rop, rr, dd, m_issue, m_err, m_cnt);
      exec($sformatf("rnd%0d", n), rop, 12'($urandom), 16'($urandom), rr, dd, m_issue, m_err, m_cnt);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
